// File: rtl/neuron_config_loader_pkg.sv
// Shared definitions for the neuron configuration loader: header layout,
// record kinds, loader states and the header decode helper.
package nn_cfg_pkg;

    // Record kind carried in the top two bits of every header word
    typedef enum logic [1:0] {
        KIND_WEIGHT = 2'b00,
        KIND_BIAS   = 2'b01,
        KIND_RSVD   = 2'b10,
        KIND_END    = 2'b11
    } cfg_kind_e;

    // Header field bit positions
    localparam int unsigned HdrKindMsb   = 31;
    localparam int unsigned HdrKindLsb   = 30;
    localparam int unsigned HdrLayerMsb  = 29;
    localparam int unsigned HdrLayerLsb  = 24;
    localparam int unsigned HdrNeuronMsb = 23;
    localparam int unsigned HdrNeuronLsb = 16;
    localparam int unsigned HdrCountMsb  = 15;
    localparam int unsigned HdrCountLsb  = 0;

    typedef enum logic [2:0] {
        StHeader,
        StWeight,
        StBias,
        StDone,
        StError
    } loader_state_e;

    typedef struct packed {
        cfg_kind_e   kind;
        logic [5:0]  layer;
        logic [7:0]  neuron;
        logic [15:0] count;
    } cfg_hdr_t;

    function automatic cfg_hdr_t decode_header(input logic [31:0] word);
        cfg_hdr_t hdr;
        hdr.kind   = cfg_kind_e'(word[HdrKindMsb:HdrKindLsb]);
        hdr.layer  = word[HdrLayerMsb:HdrLayerLsb];
        hdr.neuron = word[HdrNeuronMsb:HdrNeuronLsb];
        hdr.count  = word[HdrCountMsb:HdrCountLsb];
        return hdr;
    endfunction

endpackage

// File: rtl/neuron_config_loader_if.sv
// Input word stream plus the broadcast neuron configuration bus.
// master: the loader (consumes the stream, drives the config bus).
// slave:  the environment (config source and the neuron array).
interface neuron_config_loader_if;

    logic [31:0] s_data;
    logic        s_valid;
    logic        s_ready;
    logic        weightValid;
    logic        weightWriteEn;
    logic [31:0] weightData;
    logic        biasWriteEn;
    logic [31:0] biasData;
    logic [31:0] config_layer_number;
    logic [31:0] config_neuron_number;
    logic        busy;
    logic        done;
    logic        error;

    modport master (
        input  s_data, s_valid,
        output s_ready, weightValid, weightWriteEn, weightData, biasWriteEn, biasData,
               config_layer_number, config_neuron_number, busy, done, error
    );

    modport slave (
        output s_data, s_valid,
        input  s_ready, weightValid, weightWriteEn, weightData, biasWriteEn, biasData,
               config_layer_number, config_neuron_number, busy, done, error
    );

endinterface

// File: rtl/neuron_config_loader.sv
// Decodes a framed word stream into weight/bias write strobes on the shared
// neuron configuration bus. Every output is a register.
module neuron_config_loader
    import nn_cfg_pkg::*;
#(
    parameter int unsigned numLayers  = 4,
    parameter int unsigned maxWeights = 784,
    parameter int unsigned dataWidth  = 32
) (
    input logic                  clk,
    input logic                  reset,
    neuron_config_loader_if.master bus
);

    loader_state_e        r_state;
    logic                 r_ready;
    logic                 r_weight_valid;
    logic [dataWidth-1:0] r_weight_data;
    logic                 r_bias_we;
    logic [dataWidth-1:0] r_bias_data;
    logic [5:0]           r_layer;
    logic [7:0]           r_neuron;
    logic [15:0]          r_count;
    logic                 r_busy;
    logic                 r_done;
    logic                 r_error;

    logic [dataWidth-1:0] w_word;
    cfg_hdr_t             w_hdr;
    logic                 w_xfer;
    logic                 w_layer_ok;
    logic                 w_weight_ok;
    logic                 w_bias_ok;

    assign w_word      = bus.s_data;
    assign w_hdr       = decode_header(bus.s_data);
    assign w_xfer      = bus.s_valid & r_ready;
    assign w_layer_ok  = 32'(w_hdr.layer) < numLayers;
    assign w_weight_ok = (w_hdr.count != 16'd0) && (32'(w_hdr.count) <= maxWeights);
    assign w_bias_ok   = (w_hdr.count == 16'd1);

    // Loader FSM with all outputs registered alongside the state
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state        <= StHeader;
            r_ready        <= 1'b0;
            r_weight_valid <= 1'b0;
            r_weight_data  <= '0;
            r_bias_we      <= 1'b0;
            r_bias_data    <= '0;
            r_layer        <= '0;
            r_neuron       <= '0;
            r_count        <= '0;
            r_busy         <= 1'b0;
            r_done         <= 1'b0;
            r_error        <= 1'b0;
        end else begin
            r_weight_valid <= 1'b0;
            r_bias_we      <= 1'b0;
            unique case (r_state)
                StHeader: begin
                    r_ready <= 1'b1;
                    if (w_xfer) begin
                        if (w_hdr.kind == KIND_WEIGHT && w_weight_ok && w_layer_ok) begin
                            r_layer  <= w_hdr.layer;
                            r_neuron <= w_hdr.neuron;
                            r_count  <= w_hdr.count;
                            r_busy   <= 1'b1;
                            r_state  <= StWeight;
                        end else if (w_hdr.kind == KIND_BIAS && w_bias_ok && w_layer_ok) begin
                            r_layer  <= w_hdr.layer;
                            r_neuron <= w_hdr.neuron;
                            r_busy   <= 1'b1;
                            r_state  <= StBias;
                        end else if (w_hdr.kind == KIND_END) begin
                            r_done  <= 1'b1;
                            r_ready <= 1'b0;
                            r_state <= StDone;
                        end else begin
                            r_error <= 1'b1;
                            r_ready <= 1'b0;
                            r_state <= StError;
                        end
                    end
                end
                StWeight: begin
                    if (w_xfer) begin
                        r_weight_valid <= 1'b1;
                        r_weight_data  <= w_word;
                        r_count        <= r_count - 16'd1;
                        if (r_count == 16'd1) begin
                            r_busy  <= 1'b0;
                            r_state <= StHeader;
                        end
                    end
                end
                StBias: begin
                    if (w_xfer) begin
                        r_bias_we   <= 1'b1;
                        r_bias_data <= w_word;
                        r_busy      <= 1'b0;
                        r_state     <= StHeader;
                    end
                end
                StDone, StError: begin
                    r_ready <= 1'b0;
                end
                default: begin
                    // Unreachable encodings park in the error state
                    r_error <= 1'b1;
                    r_ready <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= StError;
                end
            endcase
        end
    end

    assign bus.s_ready              = r_ready;
    assign bus.weightValid          = r_weight_valid;
    assign bus.weightWriteEn        = r_weight_valid;
    assign bus.weightData           = r_weight_data;
    assign bus.biasWriteEn          = r_bias_we;
    assign bus.biasData             = r_bias_data;
    assign bus.config_layer_number  = {26'd0, r_layer};
    assign bus.config_neuron_number = {24'd0, r_neuron};
    assign bus.busy                 = r_busy;
    assign bus.done                 = r_done;
    assign bus.error                = r_error;

endmodule

// File: tb/tb_neuron_config_loader.sv
// Self-checking bench for neuron_config_loader: directed scenarios plus random
// record streams compared against a record-level reference parser.
module tb_neuron_config_loader;

    typedef struct {
        bit          is_bias;
        logic [31:0] data;
        logic [31:0] layer;
        logic [31:0] neuron;
        logic        wen;
        int          cyc;
    } strobe_t;

    logic clk = 1'b0;
    logic reset;
    int   tests_run = 0;
    int   tests_failed = 0;
    int   cyc = 0;

    strobe_t     strb_q[$];
    int          xfer_q[$];
    logic [31:0] stim_q[$];
    strobe_t     exp_q[$];
    bit          exp_done;
    bit          exp_err;

    neuron_config_loader_if bus();

    neuron_config_loader #(
        .numLayers  (4),
        .maxWeights (784),
        .dataWidth  (32)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Record every strobe and every stream transfer, sampled mid-cycle
    always @(negedge clk) begin
        strobe_t s;
        if (bus.weightValid === 1'b1) begin
            s.is_bias = 1'b0;
            s.data    = bus.weightData;
            s.layer   = bus.config_layer_number;
            s.neuron  = bus.config_neuron_number;
            s.wen     = bus.weightWriteEn;
            s.cyc     = cyc;
            strb_q.push_back(s);
        end
        if (bus.biasWriteEn === 1'b1) begin
            s.is_bias = 1'b1;
            s.data    = bus.biasData;
            s.layer   = bus.config_layer_number;
            s.neuron  = bus.config_neuron_number;
            s.wen     = 1'b0;
            s.cyc     = cyc;
            strb_q.push_back(s);
        end
        if (bus.s_valid === 1'b1 && bus.s_ready === 1'b1) xfer_q.push_back(cyc);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            bus.s_valid = 1'b0;
            bus.s_data  = $urandom;
            tick();
        end
    endtask

    task automatic send(input logic [31:0] w);
        bus.s_valid = 1'b1;
        bus.s_data  = w;
        tick();
        bus.s_valid = 1'b0;
    endtask

    task automatic do_reset();
        reset       = 1'b1;
        bus.s_valid = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        tick();
        strb_q = {};
        xfer_q = {};
    endtask

    // Reference: parse the accepted word list record by record
    task automatic model_stream();
        int i = 0;
        int kind, layer, neuron, count;
        strobe_t s;
        exp_q    = {};
        exp_done = 1'b0;
        exp_err  = 1'b0;
        while (i < stim_q.size()) begin
            kind   = int'(stim_q[i] >> 30);
            layer  = int'((stim_q[i] >> 24) % 64);
            neuron = int'((stim_q[i] >> 16) % 256);
            count  = int'(stim_q[i] % 65536);
            i++;
            if (kind == 3) begin
                exp_done = 1'b1;
                break;
            end else if (kind == 0 && count >= 1 && count <= 784 && layer < 4) begin
                for (int k = 0; k < count && i < stim_q.size(); k++) begin
                    s.is_bias = 1'b0;
                    s.data    = stim_q[i];
                    s.layer   = layer;
                    s.neuron  = neuron;
                    s.wen     = 1'b1;
                    s.cyc     = 0;
                    exp_q.push_back(s);
                    i++;
                end
            end else if (kind == 1 && count == 1 && layer < 4) begin
                if (i < stim_q.size()) begin
                    s.is_bias = 1'b1;
                    s.data    = stim_q[i];
                    s.layer   = layer;
                    s.neuron  = neuron;
                    s.wen     = 1'b0;
                    s.cyc     = 0;
                    exp_q.push_back(s);
                    i++;
                end
            end else begin
                exp_err = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset       = 1'b1;
        bus.s_valid = 1'b1;
        bus.s_data  = 32'h0000_0003;
        tick();
        tick();
        tests_run++;
        if (bus.s_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_ready: got %b want 0", bus.s_ready);
        end
        tests_run++;
        if ({bus.busy, bus.done, bus.error, bus.weightValid, bus.biasWriteEn} !== 5'b0) begin
            tests_failed++;
            $display("FAIL reset_flags: got %b want 00000",
                     {bus.busy, bus.done, bus.error, bus.weightValid, bus.biasWriteEn});
        end
        tests_run++;
        if ({bus.weightData, bus.biasData, bus.config_layer_number, bus.config_neuron_number}
            !== 128'd0) begin
            tests_failed++;
            $display("FAIL reset_data: got %h want 0",
                     {bus.weightData, bus.biasData, bus.config_layer_number,
                      bus.config_neuron_number});
        end
        reset       = 1'b0;
        bus.s_valid = 1'b0;
        tick();
        tests_run++;
        if (bus.s_ready !== 1'b1 || bus.busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_release: got ready=%b busy=%b want ready=1 busy=0",
                     bus.s_ready, bus.busy);
        end
        strb_q = {};
        xfer_q = {};
    endtask

    task automatic test_weight_record();
        logic [31:0] exp_w[3] = '{32'h11, 32'h22, 32'h33};
        logic        busy_seen[4];
        do_reset();
        send(32'h0000_0003);
        busy_seen[0] = bus.busy;
        send(32'h11);
        busy_seen[1] = bus.busy;
        send(32'h22);
        busy_seen[2] = bus.busy;
        send(32'h33);
        busy_seen[3] = bus.busy;
        idle(3);
        tests_run++;
        if ({busy_seen[0], busy_seen[1], busy_seen[2], busy_seen[3]} !== 4'b1110) begin
            tests_failed++;
            $display("FAIL weight_busy: got %b want 1110",
                     {busy_seen[0], busy_seen[1], busy_seen[2], busy_seen[3]});
        end
        tests_run++;
        if (strb_q.size() != 3) begin
            tests_failed++;
            $display("FAIL weight_count: got %0d strobes want 3", strb_q.size());
        end
        for (int i = 0; i < 3 && i < strb_q.size(); i++) begin
            tests_run++;
            if (strb_q[i].is_bias || strb_q[i].data !== exp_w[i] || strb_q[i].wen !== 1'b1 ||
                strb_q[i].layer !== 32'd0 || strb_q[i].neuron !== 32'd0 ||
                strb_q[i].cyc != strb_q[0].cyc + i) begin
                tests_failed++;
                $display("FAIL weight_word%0d: got bias=%0b data=%h wen=%b L=%0d N=%0d cyc+%0d want bias=0 data=%h wen=1 L=0 N=0 cyc+%0d",
                         i, strb_q[i].is_bias, strb_q[i].data, strb_q[i].wen,
                         strb_q[i].layer, strb_q[i].neuron, strb_q[i].cyc - strb_q[0].cyc,
                         exp_w[i], i);
            end
        end
    endtask

    task automatic test_bias_record();
        do_reset();
        send(32'h4105_0001);
        send(32'hFFFF_FFF0);
        idle(3);
        tests_run++;
        if (strb_q.size() != 1) begin
            tests_failed++;
            $display("FAIL bias_count: got %0d strobes want 1", strb_q.size());
        end else begin
            tests_run++;
            if (!strb_q[0].is_bias || strb_q[0].data !== 32'hFFFF_FFF0 ||
                strb_q[0].layer !== 32'd1 || strb_q[0].neuron !== 32'd5) begin
                tests_failed++;
                $display("FAIL bias_word: got bias=%0b data=%h L=%0d N=%0d want bias=1 data=fffffff0 L=1 N=5",
                         strb_q[0].is_bias, strb_q[0].data, strb_q[0].layer, strb_q[0].neuron);
            end
        end
        tests_run++;
        if (bus.config_layer_number !== 32'd1 || bus.config_neuron_number !== 32'd5 ||
            bus.busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL bias_hold: got L=%0d N=%0d busy=%b want L=1 N=5 busy=0",
                     bus.config_layer_number, bus.config_neuron_number, bus.busy);
        end
    endtask

    task automatic test_stall();
        logic [31:0] exp_w[2] = '{32'hA5A5_0001, 32'h5A5A_0002};
        do_reset();
        send(32'h0207_0002);
        send(exp_w[0]);
        idle(4);
        send(exp_w[1]);
        idle(3);
        tests_run++;
        if (strb_q.size() != 2 || xfer_q.size() != 3) begin
            tests_failed++;
            $display("FAIL stall_count: got %0d strobes %0d transfers want 2 and 3",
                     strb_q.size(), xfer_q.size());
        end else begin
            for (int i = 0; i < 2; i++) begin
                tests_run++;
                if (strb_q[i].cyc != xfer_q[i + 1] + 1 || strb_q[i].data !== exp_w[i] ||
                    strb_q[i].layer !== 32'd2 || strb_q[i].neuron !== 32'd7) begin
                    tests_failed++;
                    $display("FAIL stall_word%0d: got cyc=%0d data=%h L=%0d N=%0d want cyc=%0d data=%h L=2 N=7",
                             i, strb_q[i].cyc, strb_q[i].data, strb_q[i].layer,
                             strb_q[i].neuron, xfer_q[i + 1] + 1, exp_w[i]);
                end
            end
        end
    endtask

    task automatic test_errors();
        logic [31:0] bad[6] = '{32'h0000_0000, 32'h0400_0001, 32'h4000_0002,
                                32'h8000_0001, 32'h0000_0311, 32'h4400_0001};
        for (int i = 0; i < 6; i++) begin
            do_reset();
            send(bad[i]);
            tests_run++;
            if (bus.error !== 1'b1 || bus.s_ready !== 1'b0 || bus.busy !== 1'b0) begin
                tests_failed++;
                $display("FAIL error_hdr%0d(%h): got error=%b ready=%b busy=%b want 1 0 0",
                         i, bad[i], bus.error, bus.s_ready, bus.busy);
            end
            send(32'h0000_0001);
            send(32'h1234_5678);
            idle(2);
            tests_run++;
            if (strb_q.size() != 0 || bus.error !== 1'b1 || bus.done !== 1'b0) begin
                tests_failed++;
                $display("FAIL error_after%0d: got strobes=%0d error=%b done=%b want 0 1 0",
                         i, strb_q.size(), bus.error, bus.done);
            end
        end
    endtask

    task automatic test_end();
        bit held = 1'b1;
        do_reset();
        send(32'hC000_0000);
        tests_run++;
        if (bus.done !== 1'b1 || bus.s_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL end_done: got done=%b ready=%b want 1 0", bus.done, bus.s_ready);
        end
        for (int i = 0; i < 10; i++) begin
            send($urandom_range(0, 3) == 0 ? 32'h0000_0001 : $urandom);
            if (bus.done !== 1'b1 || bus.s_ready !== 1'b0 || bus.error !== 1'b0) held = 1'b0;
        end
        tests_run++;
        if (!held || strb_q.size() != 0) begin
            tests_failed++;
            $display("FAIL end_hold: got held=%0b strobes=%0d want 1 0", held, strb_q.size());
        end
        do_reset();
        tests_run++;
        if (bus.done !== 1'b0 || bus.s_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL end_reset: got done=%b ready=%b want 0 1", bus.done, bus.s_ready);
        end
    endtask

    task automatic test_reset_mid_record();
        do_reset();
        send(32'h0000_0005);
        send(32'h0000_0101);
        send(32'h0000_0102);
        reset       = 1'b1;
        bus.s_valid = 1'b0;
        tick();
        tests_run++;
        if (bus.weightValid !== 1'b0 || bus.busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL midreset_strobe: got weightValid=%b busy=%b want 0 0",
                     bus.weightValid, bus.busy);
        end
        tick();
        reset = 1'b0;
        tick();
        send(32'h4000_0001);
        send(32'hABCD_1234);
        idle(2);
        tests_run++;
        if (strb_q.size() != 3) begin
            tests_failed++;
            $display("FAIL midreset_count: got %0d strobes want 3", strb_q.size());
        end else begin
            tests_run++;
            if (strb_q[0].data !== 32'h101 || strb_q[1].data !== 32'h102 ||
                strb_q[0].is_bias || strb_q[1].is_bias || !strb_q[2].is_bias ||
                strb_q[2].data !== 32'hABCD_1234 || strb_q[2].layer !== 32'd0 ||
                strb_q[2].neuron !== 32'd0) begin
                tests_failed++;
                $display("FAIL midreset_words: got %h %h bias=%0b %h want 101 102 bias=1 abcd1234",
                         strb_q[0].data, strb_q[1].data, strb_q[2].is_bias, strb_q[2].data);
            end
        end
    endtask

    task automatic test_max_count();
        int bad_words = 0;
        do_reset();
        send(32'h03FF_0310);
        for (int i = 0; i < 784; i++) send(32'(i) ^ 32'h5500_0000);
        send(32'h4200_0001);
        send(32'h0BAD_F00D);
        idle(2);
        tests_run++;
        if (strb_q.size() != 785) begin
            tests_failed++;
            $display("FAIL max_count: got %0d strobes want 785", strb_q.size());
        end else begin
            for (int i = 0; i < 784; i++) begin
                if (strb_q[i].is_bias || strb_q[i].data !== (32'(i) ^ 32'h5500_0000) ||
                    strb_q[i].layer !== 32'd3 || strb_q[i].neuron !== 32'd255) bad_words++;
            end
            tests_run++;
            if (bad_words != 0 || !strb_q[784].is_bias || strb_q[784].data !== 32'h0BAD_F00D ||
                strb_q[784].layer !== 32'd2) begin
                tests_failed++;
                $display("FAIL max_words: got %0d bad weights, tail bias=%0b data=%h L=%0d want 0 1 0badf00d 2",
                         bad_words, strb_q[784].is_bias, strb_q[784].data, strb_q[784].layer);
            end
        end
    endtask

    task automatic test_random();
        for (int it = 0; it < 25; it++) begin
            int          n_rec = $urandom_range(1, 5);
            bit          stopped = 1'b0;
            logic [5:0]  lay;
            logic [7:0]  neu;
            logic [15:0] cnt;
            logic [1:0]  kind;
            stim_q = {};
            for (int r = 0; r < n_rec && !stopped; r++) begin
                int sel = $urandom_range(0, 9);
                lay = 6'($urandom_range(0, 3));
                neu = 8'($urandom_range(0, 255));
                if (sel < 6) begin
                    cnt = 16'($urandom_range(1, 6));
                    stim_q.push_back({2'b00, lay, neu, cnt});
                    for (int k = 0; k < int'(cnt); k++) stim_q.push_back($urandom);
                end else if (sel < 9) begin
                    stim_q.push_back({2'b01, lay, neu, 16'd1});
                    stim_q.push_back($urandom);
                end else begin
                    kind = 2'b00;
                    cnt  = 16'd1;
                    case ($urandom_range(0, 3))
                        0:       kind = 2'b10;
                        1:       cnt = 16'd0;
                        2:       lay = 6'($urandom_range(4, 63));
                        default: begin kind = 2'b01; cnt = 16'd2; end
                    endcase
                    stim_q.push_back({kind, lay, neu, cnt});
                    stim_q.push_back($urandom);
                    stim_q.push_back($urandom);
                    stopped = 1'b1;
                end
            end
            if (!stopped && $urandom_range(0, 1) == 1) begin
                stim_q.push_back(32'hC000_0000);
                stim_q.push_back($urandom);
            end
            do_reset();
            foreach (stim_q[i]) begin
                while ($urandom_range(0, 3) == 0) idle(1);
                send(stim_q[i]);
            end
            idle(3);
            model_stream();
            tests_run++;
            if (strb_q.size() != exp_q.size() || bus.done !== exp_done ||
                bus.error !== exp_err) begin
                tests_failed++;
                $display("FAIL rand%0d_summary: got strobes=%0d done=%b error=%b want %0d %0b %0b",
                         it, strb_q.size(), bus.done, bus.error, exp_q.size(), exp_done,
                         exp_err);
            end else begin
                for (int i = 0; i < exp_q.size(); i++) begin
                    tests_run++;
                    if (strb_q[i].is_bias != exp_q[i].is_bias ||
                        strb_q[i].data !== exp_q[i].data ||
                        strb_q[i].layer !== exp_q[i].layer ||
                        strb_q[i].neuron !== exp_q[i].neuron ||
                        strb_q[i].wen !== exp_q[i].wen) begin
                        tests_failed++;
                        $display("FAIL rand%0d_word%0d: got bias=%0b data=%h L=%0d N=%0d want bias=%0b data=%h L=%0d N=%0d",
                                 it, i, strb_q[i].is_bias, strb_q[i].data, strb_q[i].layer,
                                 strb_q[i].neuron, exp_q[i].is_bias, exp_q[i].data,
                                 exp_q[i].layer, exp_q[i].neuron);
                    end
                end
            end
        end
    endtask

    initial begin
        reset       = 1'b1;
        bus.s_valid = 1'b0;
        bus.s_data  = '0;
        test_reset();
        test_weight_record();
        test_bias_record();
        test_stall();
        test_errors();
        test_end();
        test_reset_mid_record();
        test_max_count();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/neuron_config_loader.md
# neuron_config_loader

Streams pretrained weights and biases into the neuron array over the neurons' configuration bus: the transmitting end of the `weightValid`/`weightWriteEn`/`biasWriteEn`/`config_layer_number`/`config_neuron_number` interface that each `neuron` receives. It consumes a framed 32-bit word stream (host link or boot ROM reader) with valid/ready handshake. It decodes a header per record and replays payload words as one-cycle write strobes tagged with the target layer and neuron. It sits between the configuration source and the broadcast config bus shared by every neuron in the network.

## Interface
- `numLayers`, 4: layers present; header layer ≥ this is an error.
- `maxWeights`, 784: largest legal weight count per record.
- `dataWidth`, 32: config word width; fixed at 32 (header format depends on it).

- `clk` in 1: system clock; single clock domain.
- `reset` in 1: synchronous, active-high reset.
- `s_data` in 32: input stream word.
- `s_valid` in 1: `s_data` valid.
- `s_ready` out 1: loader accepts word this cycle (transfer = `s_valid & s_ready`).
- `weightValid` out 1: one-cycle strobe, weight word on `weightData`.
- `weightWriteEn` out 1: equals `weightValid` (write, not read-back).
- `weightData` out 32: weight word.
- `biasWriteEn` out 1: one-cycle strobe, bias word on `biasData`.
- `biasData` out 32: bias word.
- `config_layer_number` out 32: target layer, zero-extended.
- `config_neuron_number` out 32: target neuron, zero-extended.
- `busy` out 1: a record payload is in progress.
- `done` out 1: END header received; sticky until reset.
- `error` out 1: malformed header; sticky until reset.

## Operation
- Header word: [31:30] kind (00 weight, 01 bias, 10 reserved, 11 end), [29:24] layer, [23:16] neuron, [15:0] count.
- FSM states: HEADER, WEIGHT, BIAS, DONE, ERROR. Reset → HEADER.
- HEADER, accepted word:
  - kind 00: count 1..`maxWeights` and layer < `numLayers` → latch layer/neuron, load counter = count → WEIGHT.
  - kind 01: count == 1 and layer legal → BIAS.
  - kind 11 → DONE.
  - Anything else (kind 10, count 0, count > limit, bias count ≠ 1, bad layer) → ERROR.
- WEIGHT: each accepted word drives `weightData`, `weightValid = weightWriteEn = 1` for one cycle and decrements the counter. The last word (counter == 1) returns to HEADER.
- BIAS: accepted word drives `biasData` and `biasWriteEn` for one cycle → HEADER.
- DONE, ERROR: terminal; `s_ready` = 0; no strobes; exit only by `reset`.
- `s_ready` = 1 in HEADER, WEIGHT, BIAS. Words with `s_valid` low are ignored, and counters and strobes hold.
- `config_layer_number`/`config_neuron_number` update only on an accepted legal header. They hold through the payload and after it.
- Header words never produce a strobe.
- `busy` = state is WEIGHT or BIAS.

## Timing
- All outputs registered. A strobe appears the cycle after its payload word's transfer and lasts exactly one cycle.
- Back-to-back payload transfers give strobes on consecutive cycles. Throughput is 1 word/cycle; per record, the header costs one dead cycle.
- `done`/`error` assert the cycle after the offending or END header transfer.
- Reset values: `s_ready` 0 during reset, 1 the cycle after; all strobes, `busy`, `done`, `error` 0; data and number outputs 0; counter 0.
- Reset mid-payload aborts the record and leaves no partial strobe the next cycle. The next accepted word is decoded as a header.
- `s_valid` deasserting mid-payload stalls with no timeout.

## Structure
- Shared package `nn_cfg_pkg`:
  - `cfg_kind_e` enum (KIND_WEIGHT, KIND_BIAS, KIND_RSVD, KIND_END).
  - Header field bit positions.
  - Loader state enum.
- Single flat module with no sub-module. The header decode is a local function in the package (`decode_header`) returning kind/layer/neuron/count.

## Test plan
- Weight record: header 0x0000_0003 (L0 N0, 3 words) then 0x11, 0x22, 0x33 continuous → three consecutive `weightValid` pulses with data 0x11/0x22/0x33, layer 0, neuron 0; `busy` high for those 3 payload cycles.
- Bias record: header 0x4105_0001 (L1 N5), then 0xFFFF_FFF0 → single `biasWriteEn` with `biasData` 0xFFFF_FFF0, layer 1, neuron 5; no `weightValid`.
- Stall: weight header count 2, payload words separated by 4 idle `s_valid` cycles → exactly 2 strobes, each one cycle after its transfer.
- Errors: each of count 0, layer 4, bias count 2, and kind 10 (each after reset) → `error` = 1 and `s_ready` = 0 next cycle; following words produce no strobe.
- END: header 0xC000_0000 → `done` = 1, `s_ready` = 0; held for 10 cycles until `reset`.
- Reset mid-record: weight count 5, reset after 2 payload words → strobes stop. After reset, word 0x4000_0001 is decoded as a bias header and followed by a correct bias write.
